// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with a valid/ready handshake.
// It carries one instruction word and N_CH data channels through a 2-entry
// skid buffer. A flush input inserts a bubble. A saturating counter records
// the cycles in which the downstream stage stalls. The capture edge is
// chosen with NEG_EDGE.
//
// Ports:
//   clock        stage clock. The active edge is falling when NEG_EDGE=1,
//                and rising when NEG_EDGE=0.
//   reset        asynchronous, active-high reset.
//   flush        drops every held entry on the next active edge.
//   i_valid      the upstream stage offers an entry.
//   o_ready      the stage can accept an entry. This is true when the skid
//                slot is empty, and it comes from a register.
//   i_insn       upstream instruction word.
//   i_data       upstream channels. Channel k is i_data[k*DATA_W +: DATA_W].
//   o_valid      the main slot holds a valid entry.
//   i_ready      the downstream stage accepts the output entry.
//   o_insn       output instruction. It is NOP_INSN while the stage is empty.
//   o_data       output channels, packed like i_data. Zero while empty.
//   o_occupancy  number of held entries, 0 to 2.
//   o_stall_cnt  saturating count of active edges with o_valid=1 and i_ready=0.
module pipe_stage_reg #(
  parameter int unsigned       INSN_W   = 32'd32,
  parameter int unsigned       DATA_W   = 32'd32,
  parameter int unsigned       N_CH     = 32'd2,
  parameter logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013,
  parameter bit                NEG_EDGE = 1'b1,
  parameter int unsigned       STALL_W  = 32'd16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [INSN_W-1:0]        i_insn,
  input  logic [N_CH*DATA_W-1:0]   i_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [INSN_W-1:0]        o_insn,
  output logic [N_CH*DATA_W-1:0]   o_data,
  output logic [1:0]               o_occupancy,
  output logic [STALL_W-1:0]       o_stall_cnt
);

  localparam int unsigned DW = N_CH * DATA_W;
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
  localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0]      DATA_ZERO = {DW{1'b0}};

  // All state updates on the rising edge of cap_clk_s. Inverting the clock
  // moves every capture onto the falling edge of clock.
  logic cap_clk_s;
  assign cap_clk_s = NEG_EDGE ? ~clock : clock;

  logic               main_vld_r, skid_vld_r;
  logic [INSN_W-1:0]  main_insn_r, skid_insn_r;
  logic [DW-1:0]      main_data_r, skid_data_r;
  logic [1:0]         occ_r;
  logic [STALL_W-1:0] stall_r;

  logic               main_vld_s, skid_vld_s;
  logic [INSN_W-1:0]  main_insn_s, skid_insn_s;
  logic [DW-1:0]      main_data_s, skid_data_s;
  logic [1:0]         occ_s;
  logic [STALL_W-1:0] stall_s;
  logic               in_s, out_s;

  // Next state of the two slots, the occupancy and the stall counter.
  always_comb begin
    in_s        = i_valid & ~skid_vld_r;
    out_s       = main_vld_r & i_ready;
    main_vld_s  = main_vld_r;
    main_insn_s = main_insn_r;
    main_data_s = main_data_r;
    skid_vld_s  = skid_vld_r;
    skid_insn_s = skid_insn_r;
    skid_data_s = skid_data_r;

    if (flush) begin
      // Drop everything, including any entry offered in the same cycle.
      main_vld_s  = 1'b0;
      main_insn_s = NOP_INSN;
      main_data_s = DATA_ZERO;
      skid_vld_s  = 1'b0;
      skid_insn_s = NOP_INSN;
      skid_data_s = DATA_ZERO;
    end else if (!main_vld_r) begin
      // The skid slot is never full while the main slot is empty.
      if (in_s) begin
        main_vld_s  = 1'b1;
        main_insn_s = i_insn;
        main_data_s = i_data;
      end else begin
        main_vld_s  = 1'b0;
        main_insn_s = NOP_INSN;
        main_data_s = DATA_ZERO;
      end
    end else if (out_s) begin
      if (skid_vld_r) begin
        // Here in_s is 0 because o_ready is low while the skid slot is full.
        main_vld_s  = 1'b1;
        main_insn_s = skid_insn_r;
        main_data_s = skid_data_r;
        skid_vld_s  = 1'b0;
        skid_insn_s = NOP_INSN;
        skid_data_s = DATA_ZERO;
      end else if (in_s) begin
        main_vld_s  = 1'b1;
        main_insn_s = i_insn;
        main_data_s = i_data;
      end else begin
        // Load a bubble so that downstream never sees stale data.
        main_vld_s  = 1'b0;
        main_insn_s = NOP_INSN;
        main_data_s = DATA_ZERO;
      end
    end else begin
      if (in_s) begin
        skid_vld_s  = 1'b1;
        skid_insn_s = i_insn;
        skid_data_s = i_data;
      end else begin
        skid_vld_s  = skid_vld_r;
        skid_insn_s = skid_insn_r;
        skid_data_s = skid_data_r;
      end
    end

    // A flush does not clear the counter. The edge that flushes still counts.
    if (main_vld_r && !i_ready) begin
      if (stall_r != STALL_MAX) begin
        stall_s = stall_r + STALL_ONE;
      end else begin
        stall_s = stall_r;
      end
    end else begin
      stall_s = stall_r;
    end

    occ_s = {1'b0, main_vld_s} + {1'b0, skid_vld_s};
  end

  // Slot, occupancy and counter registers, all cleared by the asynchronous reset.
  always_ff @(posedge cap_clk_s or posedge reset) begin
    if (reset) begin
      main_vld_r  <= 1'b0;
      main_insn_r <= NOP_INSN;
      main_data_r <= DATA_ZERO;
      skid_vld_r  <= 1'b0;
      skid_insn_r <= NOP_INSN;
      skid_data_r <= DATA_ZERO;
      occ_r       <= 2'd0;
      stall_r     <= {STALL_W{1'b0}};
    end else begin
      main_vld_r  <= main_vld_s;
      main_insn_r <= main_insn_s;
      main_data_r <= main_data_s;
      skid_vld_r  <= skid_vld_s;
      skid_insn_r <= skid_insn_s;
      skid_data_r <= skid_data_s;
      occ_r       <= occ_s;
      stall_r     <= stall_s;
    end
  end

  assign o_valid     = main_vld_r;
  assign o_ready     = ~skid_vld_r;
  assign o_insn      = main_insn_r;
  assign o_data      = main_data_r;
  assign o_occupancy = occ_r;
  assign o_stall_cnt = stall_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. Instance dut uses the default
// parameters (falling-edge capture). Instance dut2 uses STALL_W=3 and
// rising-edge capture, for the saturation and edge-select checks.
module tb_pipe_stage_reg;

  logic        clock;
  logic        reset;
  logic        flush, i_valid, i_ready, o_ready, o_valid;
  logic [31:0] i_insn, o_insn;
  logic [63:0] i_data, o_data;
  logic [1:0]  o_occupancy;
  logic [15:0] o_stall_cnt;

  logic        flush2, i_valid2, i_ready2, o_ready2, o_valid2;
  logic [31:0] i_insn2, o_insn2;
  logic [63:0] i_data2, o_data2;
  logic [1:0]  o_occupancy2;
  logic [2:0]  o_stall_cnt2;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg dut (
    .clock(clock), .reset(reset), .flush(flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_insn(i_insn), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_insn(o_insn), .o_data(o_data),
    .o_occupancy(o_occupancy), .o_stall_cnt(o_stall_cnt)
  );

  pipe_stage_reg #(.STALL_W(32'd3), .NEG_EDGE(1'b0)) dut2 (
    .clock(clock), .reset(reset), .flush(flush2),
    .i_valid(i_valid2), .o_ready(o_ready2), .i_insn(i_insn2), .i_data(i_data2),
    .o_valid(o_valid2), .i_ready(i_ready2), .o_insn(o_insn2), .o_data(o_data2),
    .o_occupancy(o_occupancy2), .o_stall_cnt(o_stall_cnt2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Step dut one active (falling) edge, then settle before sampling.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h exp 1", o_ready); end
    checks++; if (o_insn !== 32'h13) begin errors++; $display("FAIL reset_insn got %0h exp 13", o_insn); end
    checks++; if (o_data !== 64'h0) begin errors++; $display("FAIL reset_data got %0h exp 0", o_data); end
    checks++; if (o_occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", o_occupancy); end
    checks++; if (o_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", o_stall_cnt); end
  endtask

  task automatic test_pass_through();
    i_ready = 1'b1; i_valid = 1'b1; i_insn = 32'h00A00093; i_data = {32'h7, 32'h5};
    // A rising edge must not capture on the falling-edge instance.
    @(posedge clock); #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL pt_no_rise_capture got %0h exp 0", o_valid); end
    tick();
    i_valid = 1'b0;
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL pt_valid got %0h exp 1", o_valid); end
    checks++; if (o_insn !== 32'h00A00093) begin errors++; $display("FAIL pt_insn got %0h exp a00093", o_insn); end
    checks++; if (o_data !== {32'h7, 32'h5}) begin errors++; $display("FAIL pt_data got %0h exp 700000005", o_data); end
    checks++; if (o_occupancy !== 2'd1) begin errors++; $display("FAIL pt_occ got %0d exp 1", o_occupancy); end
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL pt_bubble_valid got %0h exp 0", o_valid); end
    checks++; if (o_insn !== 32'h13) begin errors++; $display("FAIL pt_bubble_insn got %0h exp 13", o_insn); end
    checks++; if (o_data !== 64'h0) begin errors++; $display("FAIL pt_bubble_data got %0h exp 0", o_data); end
  endtask

  task automatic test_back_pressure();
    i_ready = 1'b0; i_valid = 1'b1; i_insn = 32'h111; i_data = 64'hA1;
    tick();                       // A enters main. o_valid was 0, so no stall.
    i_insn = 32'h222; i_data = 64'hB2;
    tick();                       // B goes to skid. Stall count becomes 1.
    i_valid = 1'b0;
    checks++; if (o_occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ got %0d exp 2", o_occupancy); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %0h exp 0", o_ready); end
    checks++; if (o_insn !== 32'h111) begin errors++; $display("FAIL bp_insn_a got %0h exp 111", o_insn); end
    tick();                       // hold, stall count becomes 2
    checks++; if (o_stall_cnt !== 16'd2) begin errors++; $display("FAIL bp_stall_held got %0d exp 2", o_stall_cnt); end
    i_ready = 1'b1;
    tick();
    checks++; if (o_insn !== 32'h222) begin errors++; $display("FAIL bp_insn_b got %0h exp 222", o_insn); end
    checks++; if (o_data !== 64'hB2) begin errors++; $display("FAIL bp_data_b got %0h exp b2", o_data); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %0h exp 1", o_ready); end
    checks++; if (o_occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ_drain got %0d exp 1", o_occupancy); end
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0h exp 0", o_valid); end
    checks++; if (o_stall_cnt !== 16'd2) begin errors++; $display("FAIL bp_stall got %0d exp 2", o_stall_cnt); end
  endtask

  task automatic test_back_to_back();
    i_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      i_valid = 1'b1; i_insn = k; i_data = {32'(k + 100), 32'(k)};
      tick();
      checks++; if (o_insn !== 32'(k) || o_valid !== 1'b1) begin errors++; $display("FAIL stream_insn%0d got %0h exp %0h", k, o_insn, k); end
      checks++; if (o_data !== {32'(k + 100), 32'(k)}) begin errors++; $display("FAIL stream_data%0d got %0h", k, o_data); end
      checks++; if (o_occupancy > 2'd1) begin errors++; $display("FAIL stream_occ%0d got %0d exp <=1", k, o_occupancy); end
    end
    i_valid = 1'b0;
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL stream_end got %0h exp 0", o_valid); end
    checks++; if (o_stall_cnt !== 16'd2) begin errors++; $display("FAIL stream_stall got %0d exp 2", o_stall_cnt); end
  endtask

  task automatic test_flush();
    i_ready = 1'b0; i_valid = 1'b1; i_insn = 32'h444; i_data = 64'h44;
    tick();                       // stall count stays 2
    i_insn = 32'h555; i_data = 64'h55;
    tick();                       // stall count becomes 3
    checks++; if (o_occupancy !== 2'd2) begin errors++; $display("FAIL fl_pre_occ got %0d exp 2", o_occupancy); end
    flush = 1'b1; i_insn = 32'h333; i_data = 64'h33;
    tick();                       // the flush edge is a stall edge, so the count becomes 4
    flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got %0h exp 0", o_valid); end
    checks++; if (o_insn !== 32'h13) begin errors++; $display("FAIL fl_insn got %0h exp 13", o_insn); end
    checks++; if (o_data !== 64'h0) begin errors++; $display("FAIL fl_data got %0h exp 0", o_data); end
    checks++; if (o_occupancy !== 2'd0) begin errors++; $display("FAIL fl_occ got %0d exp 0", o_occupancy); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL fl_ready got %0h exp 1", o_ready); end
    checks++; if (o_stall_cnt !== 16'd4) begin errors++; $display("FAIL fl_stall got %0d exp 4", o_stall_cnt); end
    tick();
    checks++; if (o_valid !== 1'b0 || o_insn !== 32'h13) begin errors++; $display("FAIL fl_dropped got %0h exp 13", o_insn); end
  endtask

  task automatic test_async_reset();
    i_ready = 1'b0; i_valid = 1'b1; i_insn = 32'h666;
    tick();                       // stall count stays 4
    i_insn = 32'h777;
    tick();                       // stall count becomes 5
    i_valid = 1'b0;
    checks++; if (o_stall_cnt !== 16'd5 || o_occupancy !== 2'd2) begin errors++; $display("FAIL ar_pre got stall %0d occ %0d exp 5 2", o_stall_cnt, o_occupancy); end
    #2 reset = 1'b1;              // between edges
    #1;
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL ar_vr got %0h%0h exp 01", o_valid, o_ready); end
    checks++; if (o_insn !== 32'h13 || o_data !== 64'h0) begin errors++; $display("FAIL ar_payload got %0h exp 13", o_insn); end
    checks++; if (o_occupancy !== 2'd0 || o_stall_cnt !== 16'd0) begin errors++; $display("FAIL ar_cnt got occ %0d stall %0d exp 0 0", o_occupancy, o_stall_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_saturation_edge();
    logic [2:0] exp_cnt;
    @(posedge clock); #1;
    i_valid2 = 1'b1; i_insn2 = 32'h99; i_data2 = 64'h9;
    @(negedge clock); #1;
    checks++; if (o_valid2 !== 1'b0) begin errors++; $display("FAIL sat_no_fall_capture got %0h exp 0", o_valid2); end
    @(posedge clock); #1;
    i_valid2 = 1'b0;
    checks++; if (o_valid2 !== 1'b1 || o_insn2 !== 32'h99) begin errors++; $display("FAIL sat_capture got %0h exp 99", o_insn2); end
    checks++; if (o_stall_cnt2 !== 3'd0) begin errors++; $display("FAIL sat_start got %0d exp 0", o_stall_cnt2); end
    exp_cnt = 3'd0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock); #1;
      checks++; if (o_stall_cnt2 !== exp_cnt) begin errors++; $display("FAIL sat_fall%0d got %0d exp %0d", i, o_stall_cnt2, exp_cnt); end
      @(posedge clock); #1;
      exp_cnt = (i >= 7) ? 3'd7 : 3'(i);
      checks++; if (o_stall_cnt2 !== exp_cnt) begin errors++; $display("FAIL sat_rise%0d got %0d exp %0d", i, o_stall_cnt2, exp_cnt); end
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_insn = 32'h0; i_data = 64'h0;
    flush2 = 1'b0; i_valid2 = 1'b0; i_ready2 = 1'b0; i_insn2 = 32'h0; i_data2 = 64'h0;
    #1;
    test_reset();
    #11 reset = 1'b0;             // t=12, away from both edges
    test_reset();
    test_pass_through();
    test_back_pressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_saturation_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed inter-stage pipeline latches. Carries one instruction word and N_CH data channels between two processor pipeline stages.
- Adds valid/ready back-pressure through a 2-entry skid buffer, a flush input that inserts a bubble, and a saturating stall counter.
- Capture edge is selectable, so the same block serves the falling-edge stage boundaries and any rising-edge boundaries.

Parameters:
INSN_W, 32, instruction word width.
DATA_W, 32, width of each data channel.
N_CH, 2, number of data channels (e.g. ALU result, regfile B).
NOP_INSN, 32'h0000_0013, value driven on o_insn whenever the stage holds no valid entry.
NEG_EDGE, 1, 1 = capture on falling clock edge, 0 = capture on rising edge.
STALL_W, 16, stall counter width.

Ports:
clock  in  1  stage clock; active edge selected by NEG_EDGE.
reset  in  1  asynchronous, active-high reset.
flush  in  1  discard all held entries on the next active edge.
i_valid  in  1  upstream offers an entry.
o_ready  out  1  stage can accept an entry this cycle.
i_insn  in  INSN_W  upstream instruction.
i_data  in  N_CH*DATA_W  upstream channels; channel k occupies bits [k*DATA_W +: DATA_W].
o_valid  out  1  output entry is valid.
i_ready  in  1  downstream accepts the output entry.
o_insn  out  INSN_W  output instruction.
o_data  out  N_CH*DATA_W  output channels, same packing as i_data.
o_occupancy  out  2  number of held entries, 0..2.
o_stall_cnt  out  STALL_W  count of active edges with o_valid=1 and i_ready=0.

Behaviour:
- Storage: a main slot (drives the outputs) and a skid slot. A skid entry exists only when the main slot is also full.
- Reset (asynchronous, immediate, also mid-operation):
  - o_valid=0, skid empty, o_ready=1.
  - o_insn=NOP_INSN, o_data=0, o_occupancy=0, o_stall_cnt=0.
- o_ready = skid slot empty. It is a registered state and does not depend combinationally on i_ready.
- Per active edge, define in = i_valid & o_ready and out = o_valid & i_ready.
- Flush: highest priority after reset.
  - Both slots become empty; o_insn=NOP_INSN; o_data=0.
  - Any simultaneous in or out is discarded; an entry presented with flush is dropped.
- Otherwise, apply the first matching rule:
  - Main empty, in: main <= input. Latency is 1 active edge.
  - Main full, out, skid full: main <= skid; skid empties. in is impossible here because o_ready=0.
  - Main full, out, skid empty, in: main <= input. Full throughput of 1 entry per edge.
  - Main full, out, skid empty, no in: main empties.
  - Main full, no out, in: skid <= input; o_ready falls at this edge.
  - Main full, no out, no in: hold.
  - Main empty, no in: hold empty.
- Whenever the main slot is empty after an edge: o_insn=NOP_INSN and o_data=0. Downstream always sees a bubble, never stale data.
- Ordering: strict FIFO. An entry is never duplicated or dropped except by flush or reset.
- o_occupancy = main valid + skid valid; it updates with the slots.
- o_stall_cnt:
  - Increments on each active edge with o_valid=1 and i_ready=0.
  - Saturates at 2^STALL_W-1.
  - Not cleared by flush, only by reset.
  - The edge that performs a flush still counts if the stall condition held.
- All state updates on the selected edge only; no logic toggles on the opposite edge.
- i_ready and flush are sampled at the active edge.

Test Plan:
1. Reset and pass-through: release reset, hold i_ready=1, push insn 0x00A00093 with data {0x5,0x7}.
   -> o_valid=1 and o_insn=0x00A00093 after 1 active edge; o_valid=0 and o_insn=0x00000013 on the following edge.
2. Back-pressure: i_ready=0, push entries A=0x111 then B=0x222.
   -> o_occupancy=2, o_ready=0, o_insn=0x111.
   -> Raise i_ready: 0x111 then 0x222 appear on consecutive edges and o_ready returns to 1. o_stall_cnt equals the number of edges i_ready was held low with o_valid=1.
3. Streaming: i_valid=1 and i_ready=1 for 8 edges with insns 1..8.
   -> Outputs 1..8 in order, one per edge; o_occupancy never exceeds 1.
4. Flush with full skid: occupancy=2, then flush=1 with i_valid=1 (insn 0x333).
   -> Next edge: o_valid=0, o_insn=NOP_INSN, o_data=0, o_occupancy=0, o_ready=1; 0x333 never appears.
5. Asynchronous reset mid-stall: o_stall_cnt=5, occupancy=2, assert reset between edges.
   -> All outputs reach reset values immediately without waiting for a clock edge.
6. Saturation and edge select: STALL_W=3, NEG_EDGE=0, hold stall for 10 edges.
   -> o_stall_cnt stops at 7; all captures occur on rising edges only.
